// File: rtl/rpn_stack_sequencer_if.sv
// Token stream, Stack strobes and result/error status between a token source,
// the RPN sequencer and one Stack instance. State exposes the sequencer FSM for debug.
interface rpn_stack_sequencer_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  Tok_Valid;
    logic                  Tok_Ready;
    logic                  Tok_IsOp;
    logic [DATA_WIDTH-1:0] Tok_Data;
    logic                  Stk_Push;
    logic                  Stk_Pop;
    logic [DATA_WIDTH-1:0] Stk_Data_In;
    logic [DATA_WIDTH-1:0] Stk_Data_Out;
    logic                  Stk_Full;
    logic                  Stk_Empty;
    logic [DATA_WIDTH-1:0] Result;
    logic                  Result_Valid;
    logic                  Error;
    logic [1:0]            Err_Code;
    logic [2:0]            State;

    // Token handshake: a token transfers on a rising edge where Tok_Valid and
    // Tok_Ready are both 1; the source holds Tok_IsOp/Tok_Data stable while Tok_Valid=1.
    modport slave (
        input  Tok_Valid, Tok_IsOp, Tok_Data, Stk_Data_Out, Stk_Full, Stk_Empty,
        output Tok_Ready, Stk_Push, Stk_Pop, Stk_Data_In, Result, Result_Valid,
               Error, Err_Code, State
    );

    modport master (
        output Tok_Valid, Tok_IsOp, Tok_Data, Stk_Data_Out, Stk_Full, Stk_Empty,
        input  Tok_Ready, Stk_Push, Stk_Pop, Stk_Data_In, Result, Result_Valid,
               Error, Err_Code, State
    );
endinterface

// File: rtl/rpn_stack_sequencer.sv
// Postfix evaluator in front of a Stack: operands are pushed, operators pop B then A,
// compute, and push the result. Under/overflow and bad opcodes lock into a sticky error.
module rpn_stack_sequencer #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                 Clk,
    input  logic                 RstN,
    rpn_stack_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH_OP = 3'd1,
        POP_B   = 3'd2,
        CAP_B   = 3'd3,
        POP_A   = 3'd4,
        CAP_A   = 3'd5,
        PUSH_R  = 3'd6,
        ERR     = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [2:0]            op_q, op_d;
    logic                  ready_q, ready_d;
    logic                  push_q, push_d;
    logic                  pop_q, pop_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  rv_q, rv_d;
    logic                  error_q, error_d;
    logic [1:0]            code_q, code_d;
    logic [DATA_WIDTH-1:0] alu_r;

    // A arrives on Stk_Data_Out during CAP_A, so the result is formed from it directly.
    always_comb begin
        alu_r = '0;
        case (op_q)
            3'd0:    alu_r = bus.Stk_Data_Out + b_q;
            3'd1:    alu_r = bus.Stk_Data_Out - b_q;
            3'd2:    alu_r = bus.Stk_Data_Out & b_q;
            3'd3:    alu_r = bus.Stk_Data_Out | b_q;
            3'd4:    alu_r = bus.Stk_Data_Out ^ b_q;
            default: alu_r = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        op_d     = op_q;
        din_d    = din_q;
        result_d = result_q;
        code_d   = code_q;
        case (state_q)
            IDLE: begin
                if (bus.Tok_Valid && ready_q) begin
                    if (!bus.Tok_IsOp) begin
                        if (bus.Stk_Full) begin
                            state_d = ERR;
                            code_d  = 2'b10;
                        end else begin
                            din_d   = bus.Tok_Data;
                            state_d = PUSH_OP;
                        end
                    end else if (bus.Tok_Data > DATA_WIDTH'(4)) begin
                        state_d = ERR;
                        code_d  = 2'b11;
                    end else if (bus.Stk_Empty) begin
                        state_d = ERR;
                        code_d  = 2'b01;
                    end else begin
                        op_d    = bus.Tok_Data[2:0];
                        state_d = POP_B;
                    end
                end
            end
            PUSH_OP: state_d = IDLE;
            POP_B:   state_d = CAP_B;
            CAP_B: begin
                b_d = bus.Stk_Data_Out;
                // Empty after taking B means there is no A to pair it with.
                if (bus.Stk_Empty) begin
                    state_d = ERR;
                    code_d  = 2'b01;
                end else begin
                    state_d = POP_A;
                end
            end
            POP_A: state_d = CAP_A;
            CAP_A: begin
                din_d    = alu_r;
                result_d = alu_r;
                state_d  = PUSH_R;
            end
            PUSH_R:  state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        ready_d = (state_d == IDLE);
        push_d  = (state_d == PUSH_OP) || (state_d == PUSH_R);
        pop_d   = (state_d == POP_B) || (state_d == POP_A);
        rv_d    = (state_d == PUSH_R);
        error_d = (state_d == ERR);
    end

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state_q  <= IDLE;
            b_q      <= '0;
            op_q     <= '0;
            ready_q  <= 1'b0;
            push_q   <= 1'b0;
            pop_q    <= 1'b0;
            din_q    <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            error_q  <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            op_q     <= op_d;
            ready_q  <= ready_d;
            push_q   <= push_d;
            pop_q    <= pop_d;
            din_q    <= din_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            error_q  <= error_d;
            code_q   <= code_d;
        end
    end

    assign bus.Tok_Ready    = ready_q;
    assign bus.Stk_Push     = push_q;
    assign bus.Stk_Pop      = pop_q;
    assign bus.Stk_Data_In  = din_q;
    assign bus.Result       = result_q;
    assign bus.Result_Valid = rv_q;
    assign bus.Error        = error_q;
    assign bus.Err_Code     = code_q;
    assign bus.State        = state_q;
endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Directed bench for rpn_stack_sequencer driving an 8-deep behavioural Stack.
module tb_rpn_stack_sequencer;
    localparam int W = 4;

    logic Clk = 1'b0;
    logic RstN = 1'b0;
    always #5 Clk = ~Clk;

    rpn_stack_sequencer_if #(.DATA_WIDTH(W)) bus ();
    rpn_stack_sequencer #(.DATA_WIDTH(W)) dut (.Clk(Clk), .RstN(RstN), .bus(bus));

    int checks = 0;
    int failures = 0;

    // Behavioural Stack: pop data appears the cycle after the Pop edge.
    logic [W-1:0] mem [8];
    int           depth = 0;
    logic [W-1:0] stk_out = '0;
    always @(posedge Clk) begin
        if (!RstN) begin
            depth   <= 0;
            stk_out <= '0;
        end else if (bus.Stk_Push && depth < 8) begin
            mem[depth] <= bus.Stk_Data_In;
            depth      <= depth + 1;
        end else if (bus.Stk_Pop && depth > 0) begin
            stk_out <= mem[depth-1];
            depth   <= depth - 1;
        end
    end
    assign bus.Stk_Data_Out = stk_out;
    assign bus.Stk_Full     = (depth == 8);
    assign bus.Stk_Empty    = (depth == 0);

    int push_cnt = 0, pop_cnt = 0, rv_cnt = 0, both_cnt = 0;
    always @(posedge Clk) begin
        if (bus.Stk_Push) push_cnt <= push_cnt + 1;
        if (bus.Stk_Pop) pop_cnt <= pop_cnt + 1;
        if (bus.Result_Valid) rv_cnt <= rv_cnt + 1;
        if (bus.Stk_Push && bus.Stk_Pop) both_cnt <= both_cnt + 1;
    end

    task automatic do_reset();
        @(negedge Clk);
        RstN = 1'b0;
        bus.Tok_Valid = 1'b0;
        repeat (3) @(negedge Clk);
        RstN = 1'b1;
        @(negedge Clk);
    endtask

    // Sends one token and returns the number of edges after acceptance until Tok_Ready.
    task automatic send(input logic is_op, input logic [W-1:0] d, output int lat);
        int n;
        n = 0;
        lat = -1;
        while (!bus.Tok_Ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (!bus.Tok_Ready) begin
            failures++;
            $display("FAIL send_ready got=0 exp=1 tok=%0d", d);
            return;
        end
        bus.Tok_Valid = 1'b1;
        bus.Tok_IsOp  = is_op;
        bus.Tok_Data  = d;
        @(posedge Clk);
        #1 bus.Tok_Valid = 1'b0;
        lat = 0;
        while (!bus.Tok_Ready && lat < 20) begin
            @(posedge Clk);
            #1 lat++;
        end
    endtask

    task automatic test_reset();
        bus.Tok_Valid = 1'b0;
        bus.Tok_IsOp  = 1'b0;
        bus.Tok_Data  = '0;
        RstN = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({bus.Tok_Ready, bus.Stk_Push, bus.Stk_Pop, bus.Result_Valid, bus.Error} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {bus.Tok_Ready, bus.Stk_Push, bus.Stk_Pop, bus.Result_Valid, bus.Error});
        end
        checks++;
        if (bus.Result !== 4'd0 || bus.Err_Code !== 2'b00 || bus.Stk_Data_In !== 4'd0) begin
            failures++;
            $display("FAIL reset_values result=%0d code=%b din=%0d exp=0", bus.Result,
                     bus.Err_Code, bus.Stk_Data_In);
        end
        RstN = 1'b1;
        @(posedge Clk);
        #1;
        checks++;
        if (bus.Tok_Ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=1", bus.Tok_Ready);
        end
    endtask

    task automatic test_add();
        int p0, q0, r0, lat_a, lat_b, lat_op;
        do_reset();
        p0 = push_cnt; q0 = pop_cnt; r0 = rv_cnt;
        send(1'b0, 4'd4, lat_a);
        send(1'b0, 4'd6, lat_b);
        send(1'b1, 4'd0, lat_op);
        checks++;
        if (lat_a !== 1 || lat_b !== 1) begin
            failures++;
            $display("FAIL add_operand_latency got=%0d,%0d exp=1,1", lat_a, lat_b);
        end
        checks++;
        if (lat_op !== 5) begin
            failures++;
            $display("FAIL add_op_latency got=%0d exp=5", lat_op);
        end
        checks++;
        if (push_cnt - p0 !== 3 || pop_cnt - q0 !== 2) begin
            failures++;
            $display("FAIL add_strobes push=%0d pop=%0d exp=3,2", push_cnt - p0, pop_cnt - q0);
        end
        checks++;
        if (bus.Result !== 4'd10 || rv_cnt - r0 !== 1) begin
            failures++;
            $display("FAIL add_result got=%0d pulses=%0d exp=10,1", bus.Result, rv_cnt - r0);
        end
        checks++;
        if (depth !== 1 || mem[0] !== 4'd10) begin
            failures++;
            $display("FAIL add_top depth=%0d top=%0d exp=1,10", depth, mem[0]);
        end
    endtask

    task automatic test_wrap();
        int lat;
        do_reset();
        send(1'b0, 4'd3, lat);
        send(1'b0, 4'd5, lat);
        send(1'b1, 4'd1, lat);
        checks++;
        if (bus.Result !== 4'd14) begin
            failures++;
            $display("FAIL sub_wrap got=%0d exp=14", bus.Result);
        end
        send(1'b0, 4'd9, lat);
        send(1'b1, 4'd0, lat);
        checks++;
        if (bus.Result !== 4'd7 || depth !== 1) begin
            failures++;
            $display("FAIL add_wrap got=%0d depth=%0d exp=7,1", bus.Result, depth);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_reset();
        send(1'b0, 4'd12, lat);
        send(1'b0, 4'd10, lat);
        send(1'b1, 4'd2, lat);
        checks++;
        if (bus.Result !== 4'd8) begin
            failures++;
            $display("FAIL and_op got=%0d exp=8", bus.Result);
        end
        send(1'b0, 4'd5, lat);
        send(1'b1, 4'd3, lat);
        checks++;
        if (bus.Result !== 4'd13) begin
            failures++;
            $display("FAIL or_op got=%0d exp=13", bus.Result);
        end
        send(1'b0, 4'd6, lat);
        send(1'b1, 4'd4, lat);
        checks++;
        if (bus.Result !== 4'd11 || mem[0] !== 4'd11 || bus.Error !== 1'b0) begin
            failures++;
            $display("FAIL xor_op got=%0d top=%0d err=%b exp=11,11,0", bus.Result, mem[0],
                     bus.Error);
        end
        checks++;
        if (both_cnt !== 0) begin
            failures++;
            $display("FAIL push_pop_overlap got=%0d exp=0", both_cnt);
        end
    endtask

    task automatic test_empty_op();
        int q0, lat;
        do_reset();
        q0 = pop_cnt;
        send(1'b1, 4'd0, lat);
        checks++;
        if (pop_cnt - q0 !== 0 || bus.Error !== 1'b1 || bus.Err_Code !== 2'b01) begin
            failures++;
            $display("FAIL empty_op pops=%0d err=%b code=%b exp=0,1,01", pop_cnt - q0,
                     bus.Error, bus.Err_Code);
        end
        checks++;
        if (bus.Tok_Ready !== 1'b0) begin
            failures++;
            $display("FAIL empty_op_ready got=%b exp=0", bus.Tok_Ready);
        end
    endtask

    task automatic test_one_entry();
        int q0, r0, lat;
        do_reset();
        send(1'b0, 4'd12, lat);
        q0 = pop_cnt; r0 = rv_cnt;
        send(1'b1, 4'd2, lat);
        checks++;
        if (pop_cnt - q0 !== 1 || bus.Err_Code !== 2'b01 || bus.Error !== 1'b1) begin
            failures++;
            $display("FAIL one_entry pops=%0d code=%b err=%b exp=1,01,1", pop_cnt - q0,
                     bus.Err_Code, bus.Error);
        end
        checks++;
        if (rv_cnt - r0 !== 0 || bus.Stk_Push !== 1'b0 || bus.Stk_Pop !== 1'b0) begin
            failures++;
            $display("FAIL one_entry_quiet pulses=%0d push=%b pop=%b exp=0,0,0", rv_cnt - r0,
                     bus.Stk_Push, bus.Stk_Pop);
        end
    endtask

    task automatic test_full();
        int p0, q0, lat;
        do_reset();
        p0 = push_cnt;
        for (int i = 1; i <= 8; i++) send(1'b0, 4'(i), lat);
        send(1'b0, 4'd9, lat);
        checks++;
        if (push_cnt - p0 !== 8 || bus.Err_Code !== 2'b10 || bus.Error !== 1'b1) begin
            failures++;
            $display("FAIL overflow pushes=%0d code=%b err=%b exp=8,10,1", push_cnt - p0,
                     bus.Err_Code, bus.Error);
        end
        do_reset();
        p0 = push_cnt; q0 = pop_cnt;
        send(1'b1, 4'd7, lat);
        checks++;
        if (bus.Err_Code !== 2'b11 || push_cnt - p0 !== 0 || pop_cnt - q0 !== 0) begin
            failures++;
            $display("FAIL bad_opcode code=%b push=%0d pop=%0d exp=11,0,0", bus.Err_Code,
                     push_cnt - p0, pop_cnt - q0);
        end
    endtask

    task automatic test_reset_mid();
        int n, s0, lat;
        do_reset();
        send(1'b0, 4'd2, lat);
        send(1'b0, 4'd3, lat);
        @(negedge Clk);
        bus.Tok_Valid = 1'b1;
        bus.Tok_IsOp  = 1'b1;
        bus.Tok_Data  = 4'd0;
        @(posedge Clk);
        #1 bus.Tok_Valid = 1'b0;
        n = 0;
        @(negedge Clk);
        while (bus.State !== 3'd4 && n < 10) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (bus.State !== 3'd4) begin
            failures++;
            $display("FAIL mid_reach_pop_a state=%0d exp=4", bus.State);
        end
        RstN = 1'b0;
        @(posedge Clk);
        #1;
        checks++;
        if ({bus.Tok_Ready, bus.Stk_Push, bus.Stk_Pop, bus.Result_Valid, bus.Error} !== 5'b0 ||
            bus.Err_Code !== 2'b00 || bus.Result !== 4'd0 || bus.State !== 3'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs flags=%b code=%b result=%0d state=%0d exp=0",
                     {bus.Tok_Ready, bus.Stk_Push, bus.Stk_Pop, bus.Result_Valid, bus.Error},
                     bus.Err_Code, bus.Result, bus.State);
        end
        s0 = push_cnt + pop_cnt;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        RstN = 1'b1;
        @(negedge Clk);
        checks++;
        if (push_cnt + pop_cnt !== s0) begin
            failures++;
            $display("FAIL mid_reset_strobes got=%0d exp=%0d", push_cnt + pop_cnt, s0);
        end
        send(1'b0, 4'd9, lat);
        send(1'b1, 4'd0, lat);
        checks++;
        if (bus.Err_Code !== 2'b01 || bus.Error !== 1'b1) begin
            failures++;
            $display("FAIL mid_after_underflow code=%b err=%b exp=01,1", bus.Err_Code, bus.Error);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_back_to_back();
        test_empty_op();
        test_one_entry();
        test_full();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached exp=finish");
        $fatal(1, "timeout");
    end
endmodule
